pipelined_align_shifter: RTL
============================

// Module: pipelined_align_shifter
// PURPOSE
//  Pipelined, multi-mode barrel shifter for exponent alignment and normalisation in the FP adder datapath.
//  One shift level per pipeline stage; valid/ready handshake with full backpressure; one result per cycle.
//  Right shifts also produce the sticky bit (OR of discarded bits). Left shifts flag lost ones.
//  Tag field passes through unchanged to keep sideband data (sign, exponent) aligned with the result.
// PARAMETERS
//  WIDTH      16  data width; must be a power of 2, >= 4
//  AMT_WIDTH  8   shift-amount width; any value >= $clog2(WIDTH)+1
//  TAG_WIDTH  8   sideband tag width, >= 1
//  STAGES     derived = $clog2(WIDTH); pipeline depth and latency (not overridable)
// PORTS
//  clk_in        in   1          clock, rising edge
//  rst_n_in      in   1          asynchronous reset, active low
//  valid_in      in   1          input beat valid
//  ready_out     out  1          block accepts input this cycle
//  data_in       in   WIDTH      operand
//  amount_in     in   AMT_WIDTH  shift amount, unsigned
//  mode_in       in   2          00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right
//  tag_in        in   TAG_WIDTH  sideband, passed through
//  valid_out     out  1          result valid
//  ready_in      in   1          downstream accepts result
//  data_out      out  WIDTH      shifted result
//  sticky_out    out  1          right modes: OR of all bits shifted out; else 0
//  overflow_out  out  1          mode 00: 1 if any 1 bit was shifted out; else 0
//  tag_out       out  TAG_WIDTH  tag of the beat on data_out
// BEHAVIOUR
//  - Transfer in: valid_in && ready_out. Transfer out: valid_out && ready_in.
//  - ready_out = ready_in || !valid_out (global stall). Combinational from ready_in. No bubble collapse.
//  - When the pipeline advances, every stage moves forward, including empty ones (valid bit 0).
//  - Latency: a beat accepted in cycle N appears on the outputs in cycle N+STAGES if there is no stall.
//  - Stage k (k = 0..STAGES-1) shifts by 2^k when bit k of the effective amount is set.
//    It also ORs the discarded bits into the carried sticky/overflow bits.
//  - Effective amount is computed at entry and carried with the beat:
//    - amount_in < WIDTH: use amount_in.
//    - amount_in >= WIDTH, modes 00/01/10: saturated. Result is 0 for 00/01; all copies of data_in[WIDTH-1] for 10.
//      sticky_out = |data_in for 01/10. overflow_out = |data_in for 00.
//    - Mode 11: use amount_in mod WIDTH (low STAGES bits). sticky_out = 0, overflow_out = 0.
//  - Arithmetic right shift fills vacated bits with the original data_in[WIDTH-1].
//  - When stalled (valid_out && !ready_in): all stage registers and outputs hold. Outputs are stable until accepted.
//  - Reset (async assert, sync-safe release) clears all stage valid bits.
//    - valid_out = 0, data_out = 0, sticky_out = 0, overflow_out = 0, tag_out = 0.
//    - ready_out then follows the rule above (1 once out of reset).
//  - Reset mid-operation: in-flight beats are discarded. None are emitted after release.
//  - amount_in = 0 in any mode: data_out = data_in, sticky_out = 0, overflow_out = 0.
//  - Beats leave in acceptance order. tag_out always belongs to the beat on data_out.
// TESTING  (WIDTH=16, AMT_WIDTH=8)
//  1 mode 01, data 0x8001, amt 1 -> 4 cycles later data_out 0x4000, sticky_out 1, overflow_out 0.
//  2 mode 10, data 0x8000, amt 20 -> data_out 0xFFFF, sticky_out 1.
//    Mode 00, data 0x00F0, amt 12 -> data_out 0x0000, overflow_out 1.
//  3 mode 11, data 0x1234, amt 20 -> data_out 0x4123, sticky_out 0.
//    Mode 00, data 0x00F0, amt 8 -> 0xF000, overflow_out 0.
//  4 back-to-back stream, tags 1..8, ready_in low for 3 cycles once valid_out rises:
//    - ready_out low and outputs stable during the stall;
//    - all 8 results delivered in order, none lost or duplicated.
//  5 3 beats in flight, pull rst_n_in low mid-cycle:
//    - valid_out drops to 0 immediately;
//    - after release no stale beat appears, and a new beat has latency 4.
//  6 random mode/amount/data against a reference model, ready_in toggled randomly:
//    - data_out, sticky_out and overflow_out bit-exact;
//    - throughput 1 beat/cycle while ready_in is held high.

Source files
------------

// File: rtl/pipelined_align_shifter.sv
// rtl/pipelined_align_shifter.sv - pipelined multi-mode barrel shifter with sticky/overflow and tag sideband
// One power-of-two shift level per stage; a single global stall holds every stage when the output is blocked.
module pipelined_align_shifter #(
  parameter int WIDTH     = 16,
  parameter int AMT_WIDTH = 8,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [AMT_WIDTH-1:0] amount_in,
  input  logic [1:0]           mode_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 sticky_out,
  output logic                 overflow_out,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam int STAGES = $clog2(WIDTH);
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic                 st_valid  [STAGES];
  logic [WIDTH-1:0]     st_data   [STAGES];
  logic [STAGES-1:0]    st_amt    [STAGES];
  logic [1:0]           st_mode   [STAGES];
  logic                 st_fill   [STAGES];
  logic                 st_sticky [STAGES];
  logic                 st_ovf    [STAGES];
  logic [TAG_WIDTH-1:0] st_tag    [STAGES];

  logic                 src_valid  [STAGES];
  logic [WIDTH-1:0]     src_data   [STAGES];
  logic [STAGES-1:0]    src_amt    [STAGES];
  logic [1:0]           src_mode   [STAGES];
  logic                 src_fill   [STAGES];
  logic                 src_sticky [STAGES];
  logic                 src_ovf    [STAGES];
  logic [TAG_WIDTH-1:0] src_tag    [STAGES];

  logic [WIDTH-1:0]     nx_data    [STAGES];
  logic                 nx_sticky  [STAGES];
  logic                 nx_ovf     [STAGES];

  logic                 advance;
  logic                 amt_big;
  logic                 saturate;
  logic                 data_any;
  logic [WIDTH-1:0]     en_data;
  logic [STAGES-1:0]    en_amt;
  logic                 en_sticky;
  logic                 en_ovf;

  assign advance   = ready_in || !st_valid[STAGES-1];
  assign ready_out = advance;

  // Out-of-range amounts in the non-rotate modes are resolved entirely at entry,
  // so the stages only ever see an in-range amount.
  always_comb begin
    amt_big   = (amount_in >> STAGES) != '0;
    saturate  = amt_big && (mode_in != MODE_ROR);
    data_any  = |data_in;
    en_data   = data_in;
    en_amt    = amount_in[STAGES-1:0];
    en_sticky = 1'b0;
    en_ovf    = 1'b0;
    if (saturate) begin
      en_amt    = '0;
      en_data   = (mode_in == MODE_ASR) ? {WIDTH{data_in[WIDTH-1]}} : '0;
      en_sticky = (mode_in == MODE_LSR || mode_in == MODE_ASR) && data_any;
      en_ovf    = (mode_in == MODE_LSL) && data_any;
    end
  end

  always_comb begin
    src_valid[0]  = valid_in;
    src_data[0]   = en_data;
    src_amt[0]    = en_amt;
    src_mode[0]   = mode_in;
    src_fill[0]   = data_in[WIDTH-1];
    src_sticky[0] = en_sticky;
    src_ovf[0]    = en_ovf;
    src_tag[0]    = tag_in;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k]  = st_valid[k-1];
      src_data[k]   = st_data[k-1];
      src_amt[k]    = st_amt[k-1];
      src_mode[k]   = st_mode[k-1];
      src_fill[k]   = st_fill[k-1];
      src_sticky[k] = st_sticky[k-1];
      src_ovf[k]    = st_ovf[k-1];
      src_tag[k]    = st_tag[k-1];
    end
  end

  always_comb begin
    int               sh;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] high_mask;
    for (int k = 0; k < STAGES; k++) begin
      sh        = 1 << k;
      d         = src_data[k];
      low_mask  = ONES >> (WIDTH - sh);
      high_mask = ~(ONES >> sh);
      nx_data[k]   = d;
      nx_sticky[k] = src_sticky[k];
      nx_ovf[k]    = src_ovf[k];
      if (src_amt[k][k]) begin
        case (src_mode[k])
          MODE_LSL: begin
            nx_data[k] = d << sh;
            nx_ovf[k]  = src_ovf[k] | (|(d & high_mask));
          end
          MODE_LSR: begin
            nx_data[k]   = d >> sh;
            nx_sticky[k] = src_sticky[k] | (|(d & low_mask));
          end
          MODE_ASR: begin
            nx_data[k]   = (d >> sh) | (src_fill[k] ? high_mask : '0);
            nx_sticky[k] = src_sticky[k] | (|(d & low_mask));
          end
          default: begin
            nx_data[k] = (d >> sh) | (d << (WIDTH - sh));
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k]  <= 1'b0;
        st_data[k]   <= '0;
        st_amt[k]    <= '0;
        st_mode[k]   <= '0;
        st_fill[k]   <= 1'b0;
        st_sticky[k] <= 1'b0;
        st_ovf[k]    <= 1'b0;
        st_tag[k]    <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        st_valid[k]  <= src_valid[k];
        st_data[k]   <= nx_data[k];
        st_amt[k]    <= src_amt[k];
        st_mode[k]   <= src_mode[k];
        st_fill[k]   <= src_fill[k];
        st_sticky[k] <= nx_sticky[k];
        st_ovf[k]    <= nx_ovf[k];
        st_tag[k]    <= src_tag[k];
      end
    end
  end

  assign valid_out    = st_valid[STAGES-1];
  assign data_out     = st_data[STAGES-1];
  assign sticky_out   = st_sticky[STAGES-1];
  assign overflow_out = st_ovf[STAGES-1];
  assign tag_out      = st_tag[STAGES-1];

endmodule
